alu_share_arbiter: RTL and testbench

- Shares one combinational ALU instance between NUM_REQ requesters, e.g. the core execute stage, the address-generation path and a debug/CSR path.
- Arbitration is round-robin with a per-requester valid/ready handshake.
- The ALU result is captured in a single registered response slot, tagged with the winning requester's ID.
- The block sits between the requesters and the ALU and owns the ALU's a/b/alu_sel inputs.

---
 rtl/alu_share_arbiter.sv | 116 +++++++++++
 tb/tb_alu_share_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// The winning op's result lands in a single registered, ID-tagged response slot.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_ADD
`define ALU_ADD     4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB     4'h1
`endif
`ifndef ALU_AND
`define ALU_AND     4'h2
`endif
`ifndef ALU_OR
`define ALU_OR      4'h3
`endif
`ifndef ALU_XOR
`define ALU_XOR     4'h4
`endif
`ifndef ALU_SLT
`define ALU_SLT     4'h5
`endif
`ifndef ALU_SLL
`define ALU_SLL     4'h6
`endif
`ifndef ALU_INVALID
`define ALU_INVALID 4'hE
`endif
`ifndef ALU_NOP
`define ALU_NOP     4'hF
`endif

module alu_share_arbiter #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int NUM_REQ    = 2,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]          req_sel,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    output logic [3:0]                    alu_sel,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]               rsp_id
);

    logic            slot_free;
    logic            found;
    logic            grant;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] next_ptr;

    // Search starts at rr_ptr and wraps, so the last winner drops to lowest priority.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign slot_free = !rsp_valid || rsp_ready;
    assign grant     = found && slot_free && !rst;
    assign next_ptr  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    // The ALU sees the winner even while stalled; only the capture is gated.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = `ALU_NOP;
        if (found) begin
            alu_a   = req_a[winner*DATA_WIDTH +: DATA_WIDTH];
            alu_b   = req_b[winner*DATA_WIDTH +: DATA_WIDTH];
            alu_sel = req_sel[winner*4 +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
            rsp_id    <= winner;
            rr_ptr    <= next_ptr;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a 2-requester and a 3-requester arbiter, each driving a
// behavioural ALU model; expected values are hand-computed per scenario.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_ADD
`define ALU_ADD     4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB     4'h1
`endif
`ifndef ALU_AND
`define ALU_AND     4'h2
`endif
`ifndef ALU_OR
`define ALU_OR      4'h3
`endif
`ifndef ALU_XOR
`define ALU_XOR     4'h4
`endif
`ifndef ALU_SLT
`define ALU_SLT     4'h5
`endif
`ifndef ALU_SLL
`define ALU_SLL     4'h6
`endif
`ifndef ALU_INVALID
`define ALU_INVALID 4'hE
`endif
`ifndef ALU_NOP
`define ALU_NOP     4'hF
`endif

module tb_alu_share_arbiter;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [3:0] s);
        case (s)
            `ALU_ADD: return a + b;
            `ALU_SUB: return a - b;
            `ALU_AND: return a & b;
            `ALU_OR:  return a | b;
            `ALU_XOR: return a ^ b;
            `ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            `ALU_SLL: return a << b[4:0];
            `ALU_NOP: return '0;
            default:  return 32'hDEADBEEF;
        endcase
    endfunction

    // Two-requester instance
    logic [1:0]      v2;
    logic [1:0]      rdy2;
    logic [2*DW-1:0] a2, b2;
    logic [7:0]      s2;
    logic [DW-1:0]   alu_a2, alu_b2, alu_res2;
    logic [3:0]      alu_sel2;
    logic            rv2, rr2;
    logic [DW-1:0]   rd2;
    logic            rid2;

    assign alu_res2 = alu_f(alu_a2, alu_b2, alu_sel2);

    alu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(2)) u2 (
        .clk(clk), .rst(rst),
        .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .req_sel(s2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2),
        .alu_result(alu_res2),
        .rsp_valid(rv2), .rsp_ready(rr2),
        .rsp_data(rd2), .rsp_id(rid2)
    );

    // Three-requester instance
    logic [2:0]      v3;
    logic [2:0]      rdy3;
    logic [3*DW-1:0] a3, b3;
    logic [11:0]     s3;
    logic [DW-1:0]   alu_a3, alu_b3, alu_res3;
    logic [3:0]      alu_sel3;
    logic            rv3, rr3;
    logic [DW-1:0]   rd3;
    logic [1:0]      rid3;

    assign alu_res3 = alu_f(alu_a3, alu_b3, alu_sel3);

    alu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(3)) u3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .req_sel(s3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_result(alu_res3),
        .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_data(rd3), .rsp_id(rid3)
    );

    task automatic set2(input int i, input logic v, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [3:0] s);
        v2[i] = v;
        a2[i*DW +: DW] = a;
        b2[i*DW +: DW] = b;
        s2[i*4 +: 4] = s;
    endtask

    task automatic set3(input int i, input logic v, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [3:0] s);
        v3[i] = v;
        a3[i*DW +: DW] = a;
        b3[i*DW +: DW] = b;
        s3[i*4 +: 4] = s;
    endtask

    task automatic clear_inputs();
        v2 = '0; a2 = '0; b2 = '0; s2 = '0; rr2 = 1'b1;
        v3 = '0; a3 = '0; b3 = '0; s3 = '0; rr3 = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        v2 = 2'b11;
        #1;
        checks++;
        if (rv2 !== 1'b0 || rd2 !== '0 || rid2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h id=%b want 0/0/0", rv2, rd2, rid2);
        end
        checks++;
        if (rdy2 !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", rdy2);
        end
        v2 = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (alu_sel2 !== `ALU_NOP || alu_a2 !== '0 || alu_b2 !== '0) begin
            errors++;
            $display("FAIL idle_alu_drive: sel=%h a=%h b=%h want F/0/0", alu_sel2, alu_a2, alu_b2);
        end
    endtask

    task automatic test_single();
        do_reset();
        set2(0, 1'b1, 32'd5, 32'd7, `ALU_ADD);
        #1;
        checks++;
        if (rdy2 !== 2'b01 || alu_sel2 !== `ALU_ADD) begin
            errors++;
            $display("FAIL single_ready: ready=%b sel=%h want 01/0", rdy2, alu_sel2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rv2 !== 1'b1 || rd2 !== 32'd12 || rid2 !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: valid=%b data=%0d id=%b want 1/12/0", rv2, rd2, rid2);
        end
        set2(0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        checks++;
        if (rv2 !== 1'b0 || rd2 !== 32'd12) begin
            errors++;
            $display("FAIL single_drain: valid=%b data=%0d want 0/12", rv2, rd2);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_rdy;
        logic [DW-1:0] exp_d;
        do_reset();
        set2(0, 1'b1, 32'd10, 32'd3, `ALU_SUB);
        set2(1, 1'b1, 32'hF0, 32'h0F, `ALU_XOR);
        for (int k = 0; k < 4; k++) begin
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d   = (k % 2 == 0) ? 32'd7 : 32'hFF;
            #1;
            checks++;
            if (rdy2 !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, rdy2, exp_rdy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (rv2 !== 1'b1 || rd2 !== exp_d || rid2 !== exp_rdy[1]) begin
                errors++;
                $display("FAIL rr_rsp[%0d]: valid=%b data=%h id=%b want 1/%h/%b",
                         k, rv2, rd2, rid2, exp_d, exp_rdy[1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rr2 = 1'b0;
        set2(0, 1'b1, 32'd2, 32'd3, `ALU_ADD);
        @(posedge clk);
        #1;
        set2(0, 1'b0, '0, '0, '0);
        set2(1, 1'b1, 32'hFFFF_FFFF, 32'd1, `ALU_SLT);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rv2 !== 1'b1 || rd2 !== 32'd5 || rid2 !== 1'b0 || rdy2 !== 2'b00) begin
                errors++;
                $display("FAIL stall[%0d]: valid=%b data=%0d id=%b ready=%b want 1/5/0/00",
                         k, rv2, rd2, rid2, rdy2);
            end
            @(negedge clk);
        end
        rr2 = 1'b1;
        #1;
        checks++;
        if (rdy2 !== 2'b10) begin
            errors++;
            $display("FAIL stall_release_ready: got %b want 10", rdy2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rv2 !== 1'b1 || rd2 !== 32'd1 || rid2 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_rsp: valid=%b data=%0d id=%b want 1/1/1", rv2, rd2, rid2);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set3(2, 1'b1, 32'd1, 32'd4, `ALU_SLL);
        #1;
        checks++;
        if (rdy3 !== 3'b100) begin
            errors++;
            $display("FAIL wrap_first_ready: got %b want 100", rdy3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rv3 !== 1'b1 || rd3 !== 32'd16 || rid3 !== 2'd2) begin
            errors++;
            $display("FAIL wrap_first_rsp: valid=%b data=%0d id=%0d want 1/16/2", rv3, rd3, rid3);
        end
        set3(2, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        set3(0, 1'b1, 32'd1, 32'd1, `ALU_ADD);
        set3(2, 1'b1, 32'd1, 32'd4, `ALU_SLL);
        #1;
        checks++;
        if (rdy3 !== 3'b001) begin
            errors++;
            $display("FAIL wrap_tie_ready: got %b want 001", rdy3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd3 !== 32'd2 || rid3 !== 2'd0) begin
            errors++;
            $display("FAIL wrap_tie_rsp0: data=%0d id=%0d want 2/0", rd3, rid3);
        end
        set3(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        #1;
        checks++;
        if (rdy3 !== 3'b100) begin
            errors++;
            $display("FAIL wrap_tie_ready2: got %b want 100", rdy3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd3 !== 32'd16 || rid3 !== 2'd2) begin
            errors++;
            $display("FAIL wrap_tie_rsp2: data=%0d id=%0d want 16/2", rd3, rid3);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rr2 = 1'b0;
        set2(1, 1'b1, 32'd9, 32'd9, `ALU_ADD);
        @(posedge clk);
        #1;
        checks++;
        if (rv2 !== 1'b1 || rid2 !== 1'b1 || rd2 !== 32'd18) begin
            errors++;
            $display("FAIL areset_pre: valid=%b id=%b data=%0d want 1/1/18", rv2, rid2, rd2);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rv2 !== 1'b0 || rid2 !== 1'b0 || rd2 !== '0) begin
            errors++;
            $display("FAIL areset_clear: valid=%b id=%b data=%0d want 0/0/0", rv2, rid2, rd2);
        end
        @(negedge clk);
        rst = 1'b0;
        rr2 = 1'b1;
        set2(0, 1'b1, 32'd4, 32'd1, `ALU_SUB);
        #1;
        checks++;
        if (rdy2 !== 2'b01) begin
            errors++;
            $display("FAIL areset_tie: got %b want 01", rdy2);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        set2(0, 1'b1, 32'd1, 32'd2, `ALU_INVALID);
        #1;
        checks++;
        if (alu_sel2 !== `ALU_INVALID) begin
            errors++;
            $display("FAIL invalid_pass: sel=%h want E", alu_sel2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rv2 !== 1'b1 || rd2 !== 32'hDEADBEEF || rid2 !== 1'b0) begin
            errors++;
            $display("FAIL invalid_rsp: valid=%b data=%h id=%b want 1/deadbeef/0", rv2, rd2, rid2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_invalid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
